// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
package fp_pkg;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   localparam int unsigned FLAG_W        = 5;
   localparam int unsigned FLG_INVALID   = 4;
   localparam int unsigned FLG_OVERFLOW  = 3;
   localparam int unsigned FLG_UNDERFLOW = 2;
   localparam int unsigned FLG_INEXACT   = 1;
   localparam int unsigned FLG_ZERO      = 0;

   function automatic int unsigned fp_bias(input int unsigned exp_w);
      return (32'd1 << (exp_w - 32'd1)) - 32'd1;
   endfunction

   // Positive quiet NaN: exponent all ones, mantissa MSB set, rest clear.
   function automatic logic [63:0] fp_canon_nan(input int unsigned exp_w, input int unsigned man_w);
      return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'd1));
   endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits a float word into sign, effective exponent, mantissa with implicit bit and class.
// FP_MULT_SUBNORMAL_EN keeps subnormals; otherwise they are read as signed zero.
module fp_unpack
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
) (
   input  logic [EXP_W+MAN_W:0] word,
   output logic                 sign,
   output logic [EXP_W-1:0]     expo,
   output logic [MAN_W:0]       man,
   output fp_class_e            cls
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;

   assign exp_f = word[EXP_W+MAN_W-1:MAN_W];
   assign man_f = word[MAN_W-1:0];
   assign sign  = word[EXP_W+MAN_W];

   always_comb begin
      expo = exp_f;
      man  = {1'b1, man_f};
      cls  = CLS_NORM;
      if (exp_f == '1) begin
         cls = (man_f == '0) ? CLS_INF : CLS_NAN;
      end else if (exp_f == '0) begin
         if (man_f == '0) begin
            cls = CLS_ZERO;
            man = '0;
         end else begin
`ifdef FP_MULT_SUBNORMAL_EN
            cls  = CLS_SUB;
            expo = EXP_W'(1);
            man  = {1'b0, man_f};
`else
            cls  = CLS_ZERO;
            man  = '0;
`endif
         end
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined float multiplier with valid/ready flow control and RNE rounding.
// FP_MULT_SUBNORMAL_EN enables gradual underflow; default build flushes subnormals to zero.
module fp_mult_pipe
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [EXP_W+MAN_W:0] x,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4:0]           flags
);

   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned PW   = 2 * MAN_W + 2;
   localparam int unsigned SW   = EXP_W + 2;
   localparam int unsigned LZW  = $clog2(PW + 1);
   localparam int unsigned EW   = SW + LZW + 1;
   localparam int unsigned BIAS = fp_bias(EXP_W);
   localparam int unsigned EMAX = (32'd1 << EXP_W) - 32'd1;
   localparam logic [W-1:0] QNAN = W'(fp_canon_nan(EXP_W, MAN_W));

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // S1 operand decode and special-value resolution
   logic             ua_sign, ub_sign;
   logic [EXP_W-1:0] ua_exp, ub_exp;
   logic [MAN_W:0]   ua_man, ub_man;
   fp_class_e        ua_cls, ub_cls;

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .word(a), .sign(ua_sign), .expo(ua_exp), .man(ua_man), .cls(ua_cls));
   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .word(b), .sign(ub_sign), .expo(ub_exp), .man(ub_man), .cls(ub_cls));

   logic              sign_c, nan_in_c, inf_in_c, zero_in_c;
   logic              spec_c;
   logic [W-1:0]      spec_x_c;
   logic [FLAG_W-1:0] spec_flags_c;

   always_comb begin
      sign_c       = ua_sign ^ ub_sign;
      nan_in_c     = (ua_cls == CLS_NAN) || (ub_cls == CLS_NAN);
      inf_in_c     = (ua_cls == CLS_INF) || (ub_cls == CLS_INF);
      zero_in_c    = (ua_cls == CLS_ZERO) || (ub_cls == CLS_ZERO);
      spec_c       = 1'b0;
      spec_x_c     = '0;
      spec_flags_c = '0;
      if (nan_in_c || (inf_in_c && zero_in_c)) begin
         spec_c                    = 1'b1;
         spec_x_c                  = QNAN;
         spec_flags_c[FLG_INVALID] = !nan_in_c;
      end else if (inf_in_c) begin
         spec_c   = 1'b1;
         spec_x_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (zero_in_c) begin
         spec_c                 = 1'b1;
         spec_x_c               = {sign_c, (W-1)'(0)};
         spec_flags_c[FLG_ZERO] = 1'b1;
      end
   end

   logic              s1_valid, s1_sign, s1_spec;
   logic [W-1:0]      s1_spec_x;
   logic [FLAG_W-1:0] s1_spec_flags;
   logic [EXP_W-1:0]  s1_ea, s1_eb;
   logic [MAN_W:0]    s1_ma, s1_mb;

   logic                 s2_valid, s2_sign, s2_spec;
   logic [W-1:0]         s2_spec_x;
   logic [FLAG_W-1:0]    s2_spec_flags;
   logic signed [SW-1:0] s2_exp;
   logic [PW-1:0]        s2_prod;

   // S3 normalise, denormalise or flush, round, pack
   logic [LZW-1:0]       lz;
   logic [PW-1:0]        m, m_d;
   logic signed [EW-1:0] er, exp_f;
   logic                 tiny, flush, guard, rest, round_up, inexact;
   logic [MAN_W:0]       kept;
   logic [MAN_W+1:0]     sum;
   logic [W-1:0]         res_x_c;
   logic [FLAG_W-1:0]    res_flags_c;
`ifdef FP_MULT_SUBNORMAL_EN
   logic [EW-1:0]        sh;
`endif

   always_comb begin
`ifdef FP_MULT_SUBNORMAL_EN
      lz = LZW'(PW);
      for (int i = 0; i < PW; i++) begin
         if (s2_prod[i]) lz = LZW'(PW - 1 - i);
      end
`else
      lz = s2_prod[PW-1] ? '0 : LZW'(1);
`endif
      m     = s2_prod << lz;
      er    = EW'(s2_exp) + EW'(1) - EW'(lz);
      tiny  = er[EW-1] || (er == '0);
      m_d   = m;
      flush = 1'b0;
      if (tiny) begin
`ifdef FP_MULT_SUBNORMAL_EN
         sh = EW'(1) - er;
         if (sh >= EW'(PW)) m_d = PW'(|m);
         else m_d = (m >> sh) | PW'(|(m & ~({PW{1'b1}} << sh)));
`else
         flush = 1'b1;
`endif
      end
`ifdef FP_MULT_SUBNORMAL_EN
      else begin
         sh = '0;
      end
`endif
      kept     = m_d[PW-1 -: MAN_W+1];
      guard    = m_d[MAN_W];
      rest     = |m_d[MAN_W-1:0];
      round_up = guard && (rest || kept[0]);
      inexact  = guard || rest;
      sum      = {1'b0, kept} + (MAN_W+2)'(round_up);
      // Top two sum bits fold in the implicit bit and any rounding carry-out.
      exp_f    = (tiny ? EW'(0) : er - EW'(1)) + EW'(sum[MAN_W+1:MAN_W]);

      res_x_c     = '0;
      res_flags_c = '0;
      if (s2_spec) begin
         res_x_c     = s2_spec_x;
         res_flags_c = s2_spec_flags;
      end else if (flush) begin
         res_x_c                    = {s2_sign, (W-1)'(0)};
         res_flags_c[FLG_UNDERFLOW] = 1'b1;
         res_flags_c[FLG_INEXACT]   = 1'b1;
         res_flags_c[FLG_ZERO]      = 1'b1;
      end else if (exp_f >= EW'(EMAX)) begin
         res_x_c                   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         res_flags_c[FLG_OVERFLOW] = 1'b1;
         res_flags_c[FLG_INEXACT]  = 1'b1;
      end else begin
         res_x_c                    = {s2_sign, exp_f[EXP_W-1:0], sum[MAN_W-1:0]};
         res_flags_c[FLG_INEXACT]   = inexact;
         res_flags_c[FLG_UNDERFLOW] = tiny && inexact;
         res_flags_c[FLG_ZERO]      = (exp_f[EXP_W-1:0] == '0) && (sum[MAN_W-1:0] == '0);
      end
   end

   // Stage valids and the output register; reset drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         x         <= '0;
         flags     <= '0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            x     <= res_x_c;
            flags <= res_flags_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         s1_sign       <= sign_c;
         s1_spec       <= spec_c;
         s1_spec_x     <= spec_x_c;
         s1_spec_flags <= spec_flags_c;
         s1_ea         <= ua_exp;
         s1_eb         <= ub_exp;
         s1_ma         <= ua_man;
         s1_mb         <= ub_man;
         s2_sign       <= s1_sign;
         s2_spec       <= s1_spec;
         s2_spec_x     <= s1_spec_x;
         s2_spec_flags <= s1_spec_flags;
         s2_exp        <= $signed(SW'(s1_ea)) + $signed(SW'(s1_eb)) - $signed(SW'(BIAS));
         s2_prod       <= PW'(s1_ma) * PW'(s1_mb);
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Table-driven scoreboard bench for fp_mult_pipe at fp16 defaults.
module tb_fp_mult_pipe;

   localparam int unsigned EXP_W = 5;
   localparam int unsigned MAN_W = 10;
   localparam int unsigned W     = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b, x;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [4:0]   flags;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;

   typedef struct packed {
      logic [W-1:0] x;
      logic [4:0]   f;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      res_t         r;
   } vec_t;

   res_t sb[$];

   always #5 clk = ~clk;

   fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .out_valid(out_valid), .out_ready(out_ready), .flags(flags));

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [W-1:0] vx, input logic [4:0] vf);
      vec_t v;
      v.a   = va;
      v.b   = vb;
      v.r.x = vx;
      v.r.f = vf;
      return v;
   endfunction

   // One cycle: drive at negedge, score any output transfer, push expected on acceptance.
   task automatic step(input logic iv, input vec_t v, input logic ordy, output logic acc);
      res_t want;
      @(negedge clk);
      out_ready = ordy;
      in_valid  = iv;
      a         = v.a;
      b         = v.b;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got x=%h flags=%b, expected no output", x, flags);
         end else begin
            want = sb.pop_front();
            check($sformatf("x(%0d)", n_out), 32'(x), 32'(want.x));
            check($sformatf("flags(%0d)", n_out), 32'(flags), 32'(want.f));
            n_out++;
         end
      end
      acc = iv && in_ready;
      if (acc) sb.push_back(v.r);
   endtask

   task automatic drain();
      logic acc;
      vec_t idle;
      idle = mk(16'h0, 16'h0, 16'h0, 5'b0);
      for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, idle, 1'b1, acc);
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      vec_t tbl[16];
      vec_t idle;
      logic acc, prev_stall, saw_block;
      logic [W+4:0] px;
      int idx, n0, lat;

      // {a, b, x, flags={invalid, overflow, underflow, inexact, zero}}
      tbl[0]  = mk(16'h4766, 16'h4826, 16'h53AC, 5'b00010);
      tbl[1]  = mk(16'hC000, 16'h4200, 16'hC600, 5'b00000);
      tbl[2]  = mk(16'h3C01, 16'h3C01, 16'h3C02, 5'b00010);
      tbl[3]  = mk(16'h7BFF, 16'h7BFF, 16'h7C00, 5'b01010);
      tbl[4]  = mk(16'h7C00, 16'h0000, 16'h7E00, 5'b10000);
      tbl[5]  = mk(16'h7E01, 16'h3C00, 16'h7E00, 5'b00000);
      tbl[6]  = mk(16'h3E00, 16'h3C01, 16'h3E02, 5'b00010);
      tbl[7]  = mk(16'h3E00, 16'h3C03, 16'h3E04, 5'b00010);
      tbl[8]  = mk(16'h3DA8, 16'h3DA8, 16'h4000, 5'b00010);
      tbl[9]  = mk(16'h8000, 16'h3C00, 16'h8000, 5'b00001);
      tbl[10] = mk(16'hFC00, 16'h4000, 16'hFC00, 5'b00000);
      tbl[11] = mk(16'h7C00, 16'h8000, 16'h7E00, 5'b10000);
      tbl[12] = mk(16'h3C00, 16'h3C00, 16'h3C00, 5'b00000);
`ifdef FP_MULT_SUBNORMAL_EN
      tbl[13] = mk(16'h0001, 16'h3C00, 16'h0001, 5'b00000);
      tbl[14] = mk(16'h0400, 16'h3800, 16'h0200, 5'b00000);
      tbl[15] = mk(16'h0001, 16'h0001, 16'h0000, 5'b00111);
`else
      tbl[13] = mk(16'h0001, 16'h3C00, 16'h0000, 5'b00001);
      tbl[14] = mk(16'h0400, 16'h3800, 16'h0000, 5'b00111);
      tbl[15] = mk(16'h0001, 16'h0001, 16'h0000, 5'b00001);
`endif
      idle = mk(16'h0, 16'h0, 16'h0, 5'b0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_x", 32'(x), 32'd0);
      check("reset_flags", 32'(flags), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Table vectors streamed back to back
      foreach (tbl[i]) step(1'b1, tbl[i], 1'b1, acc);
      drain();

      // Latency of a single isolated operation
      step(1'b1, tbl[0], 1'b1, acc);
      n0  = n_out;
      lat = 0;
      while (n_out == n0 && lat < 10) begin
         step(1'b0, idle, 1'b1, acc);
         lat++;
      end
      check("latency", 32'(lat), 32'd3);

      // Backpressure: six pairs, consumer stalls for cycles 4..7
      idx        = 0;
      n0         = n_out;
      prev_stall = 1'b0;
      saw_block  = 1'b0;
      px         = '0;
      for (int k = 0; k < 30; k++) begin
         if (idx < 6) step(1'b1, tbl[idx], !(k >= 4 && k <= 7), acc);
         else step(1'b0, idle, !(k >= 4 && k <= 7), acc);
         if (prev_stall) begin
            check("stall_hold_x", 32'({x, flags}), 32'(px));
            check("stall_hold_valid", 32'(out_valid), 32'd1);
         end
         if (out_valid && !out_ready && !in_ready) saw_block = 1'b1;
         prev_stall = out_valid && !out_ready;
         px         = {x, flags};
         if (acc) idx++;
      end
      check("bp_accepted", 32'(idx), 32'd6);
      check("bp_delivered", 32'(n_out - n0), 32'd6);
      check("bp_in_ready_fell", 32'(saw_block), 32'd1);
      check("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Reset with two results in flight
      step(1'b1, tbl[2], 1'b1, acc);
      drain();
      step(1'b1, tbl[0], 1'b1, acc);
      step(1'b1, tbl[1], 1'b1, acc);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      sb.delete();
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      check("rst2_x", 32'(x), 32'd0);
      check("rst2_flags", 32'(flags), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, idle, 1'b1, acc);
         check("rst2_no_output", 32'(out_valid), 32'd0);
      end
      step(1'b1, tbl[1], 1'b1, acc);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
